// File: rtl/lc3b_types.sv
// ---------------------------------------------------------------------------
// lc3b_types
// Shared LC-3b type definitions used by the branch-target-buffer update path.
//   lc3b_word        : 16-bit machine word
//   btb_uq_entry_t   : one buffered branch resolution (pc, target, taken)
//   BTB_UQ_DEFAULT_DEPTH : default number of buffered resolutions
// ---------------------------------------------------------------------------
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    localparam int BTB_UQ_DEFAULT_DEPTH = 4;

    typedef struct packed {
        lc3b_word pc;
        lc3b_word target;
        logic     taken;
    } btb_uq_entry_t;

endpackage : lc3b_types

// File: rtl/btb_update_queue.sv
// ---------------------------------------------------------------------------
// btb_update_queue
// Circular FIFO that buffers resolved branches from execute/memory and
// drains them, one per cycle, into the BTB write port whenever that port
// is free. Entries issue strictly in arrival order; resolutions arriving
// while the queue is full are dropped and counted.
//
// Parameters
//   DEPTH       : number of entries (power of two, 2..16)
// Ports
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   res_valid   : resolved branch presented this cycle
//   res_pc      : PC of the resolved branch
//   res_target  : resolved target
//   res_taken   : resolved direction
//   res_ready   : queue accepts res_* this cycle
//   btb_busy    : BTB write port unavailable this cycle
//   wb_enable   : write-back request (head entry is consumed when high)
//   wb_pc       : head entry PC
//   wb_target   : head entry target
//   wb_taken    : head entry direction
//   drop_count  : saturating count of rejected resolutions
//
// Build option
//   BTB_UPDATE_COALESCE_EN : when defined, a resolution whose PC matches the
//   newest buffered entry (and that entry is not leaving this cycle) updates
//   that entry in place instead of taking a new slot, even when full.
// ---------------------------------------------------------------------------
module btb_update_queue
    import lc3b_types::*;
#(
    parameter int DEPTH = BTB_UQ_DEFAULT_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    input  lc3b_word   res_pc,
    input  lc3b_word   res_target,
    input  logic       res_taken,
    output logic       res_ready,
    input  logic       btb_busy,
    output logic       wb_enable,
    output lc3b_word   wb_pc,
    output lc3b_word   wb_target,
    output logic       wb_taken,
    output logic [7:0] drop_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // Advance a pointer with wrap from the last slot back to slot 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

`ifdef BTB_UPDATE_COALESCE_EN
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    // Step a pointer back by one slot; used to locate the newest entry.
    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        if (p == {PTR_W{1'b0}}) begin
            return LAST_PTR;
        end else begin
            return p - PTR_W'(1);
        end
    endfunction

    logic [PTR_W-1:0] newest_ptr_s;
`endif

    btb_uq_entry_t    mem_q [DEPTH];
    btb_uq_entry_t    mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       drop_count_q, drop_count_d;

    btb_uq_entry_t    head_entry_s;
    btb_uq_entry_t    new_entry_s;
    logic             not_empty_s;
    logic             full_s;
    logic             coalesce_s;
    logic             enq_s;
    logic             deq_s;
    logic             drop_s;

    // Handshake decode: drain request, accept/coalesce/drop decisions.
    always_comb begin
        head_entry_s = mem_q[head_q];
        new_entry_s  = '{pc: res_pc, target: res_target, taken: res_taken};
        not_empty_s  = (count_q != {CNT_W{1'b0}});
        full_s       = (count_q == FULL_CNT);
        wb_enable    = not_empty_s && !btb_busy;
        deq_s        = wb_enable;
`ifdef BTB_UPDATE_COALESCE_EN
        newest_ptr_s = ptr_dec(tail_q);
        // A single buffered entry that is leaving this cycle cannot absorb
        // the update; it must take a fresh slot instead.
        if (res_valid && not_empty_s && (mem_q[newest_ptr_s].pc == res_pc)
            && !(deq_s && (count_q == ONE_CNT))) begin
            coalesce_s = 1'b1;
        end else begin
            coalesce_s = 1'b0;
        end
`else
        coalesce_s   = 1'b0;
`endif
        // Readiness looks only at current occupancy, so a full queue stays
        // closed even on a cycle where the head is draining.
        res_ready    = !full_s || coalesce_s;
        enq_s        = res_valid && res_ready && !coalesce_s;
        drop_s       = res_valid && !res_ready;
        wb_pc        = head_entry_s.pc;
        wb_target    = head_entry_s.target;
        wb_taken     = head_entry_s.taken;
        drop_count   = drop_count_q;
    end

    // Next-state for storage, pointers, occupancy and drop counter.
    always_comb begin
        mem_d = mem_q;
        if (enq_s) begin
            mem_d[tail_q] = new_entry_s;
        end else begin
`ifdef BTB_UPDATE_COALESCE_EN
            if (coalesce_s) begin
                mem_d[newest_ptr_s].target = res_target;
                mem_d[newest_ptr_s].taken  = res_taken;
            end else begin
                mem_d = mem_q;
            end
`else
            mem_d = mem_q;
`endif
        end

        head_d = deq_s ? ptr_inc(head_q) : head_q;
        tail_d = enq_s ? ptr_inc(tail_q) : tail_q;

        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (drop_s && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end else begin
            drop_count_d = drop_count_q;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q       <= {PTR_W{1'b0}};
            tail_q       <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            drop_count_q <= 8'd0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Entry storage; contents are meaningless once count is zero, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule : btb_update_queue

// File: doc/btb_update_queue.md
BTB_UPDATE_QUEUE -- requirements
Module: btb_update_queue

Interface
REQ-001 The parameter list SHALL be: DEPTH, 4, number of buffered branch-resolution entries (power of two, 2..16).
REQ-002 The port list SHALL be: clk  in  1  sole clock, all state updates on its rising edge.
REQ-003 The port list SHALL continue: rst_n  in  1  reset, synchronous and active-low.
REQ-004 The port list SHALL continue: res_valid  in  1  resolved branch presented by the execute/memory stage.
REQ-005 The port list SHALL continue: res_pc  in  16  (lc3b_word) PC of the resolved branch.
REQ-006 The port list SHALL continue: res_target  in  16  (lc3b_word) resolved target.
REQ-007 The port list SHALL continue: res_taken  in  1  resolved direction.
REQ-008 The port list SHALL continue: res_ready  out  1  queue accepts res_* this cycle.
REQ-009 The port list SHALL continue: btb_busy  in  1  BTB write port unavailable this cycle.
REQ-010 The port list SHALL continue: wb_enable  out  1  write-back request to the BTB controller.
REQ-011 The port list SHALL continue: wb_pc, wb_target  out  16 each  head entry fields.
REQ-012 The port list SHALL continue: wb_taken  out  1  head entry direction.
REQ-013 The port list SHALL continue: drop_count  out  8  saturating count of rejected resolutions.

Function
REQ-014 The block SHALL be a circular FIFO with head pointer, tail pointer and occupancy count 0..DEPTH; both pointers SHALL wrap from DEPTH-1 to 0.
REQ-015 An enqueue SHALL occur when res_valid && res_ready; the entry SHALL be written at tail and SHALL first be visible on wb_* the next cycle (no bypass; minimum latency 1).
REQ-016 res_ready SHALL be 1 when count < DEPTH; otherwise 0, except as in REQ-024.
REQ-017 wb_enable SHALL be (count != 0) && !btb_busy; wb_pc/wb_target/wb_taken SHALL always show the head entry, undefined content permitted when empty.
REQ-018 A dequeue SHALL occur exactly on cycles where wb_enable is 1; head SHALL advance by one.
REQ-019 Simultaneous enqueue and dequeue SHALL leave count unchanged; when full, res_ready is 0 even if a dequeue occurs the same cycle.
REQ-020 btb_busy high SHALL hold the head entry and all wb_* outputs stable; no entry is ever lost while busy.
REQ-021 res_valid && !res_ready SHALL increment drop_count, saturating at 255 (no wrap).
REQ-022 Entries SHALL issue in strict arrival order.

Reset
REQ-023 On a rising clk with rst_n low: count, head, tail and drop_count SHALL be 0; wb_enable 0 and res_ready 1 from the following cycle; stored entries discarded; a reset asserted mid-drain SHALL abort all pending writes.

Configuration
REQ-024 With BTB_UPDATE_COALESCE_EN defined: if res_valid, count > 0, res_pc equals the newest entry's pc, and that entry is not dequeued this cycle, then target/taken SHALL be overwritten in place, count unchanged, and res_ready SHALL be 1 even when full.
REQ-025 Without BTB_UPDATE_COALESCE_EN, every accepted resolution SHALL occupy its own entry and no PC comparator SHALL exist.

Structure
REQ-026 The entry struct (pc, target, taken) and the default depth constant SHALL live in lc3b_types; lc3b_word SHALL be reused for 16-bit fields.
REQ-027 No sub-module SHALL be used; storage, pointers and counters SHALL reside in btb_update_queue.

Verification
REQ-028 Reset, then enqueue pc=0x1000, tgt=0x1040, taken=1 with btb_busy=0 -> next cycle wb_enable=1 with those values; the cycle after, wb_enable=0.
REQ-029 Hold btb_busy=1, enqueue 5 entries pc=0x2000..0x2008 -> res_ready=0 after the 4th; the 5th is rejected; drop_count=1; wb_pc stays 0x2000.
REQ-030 Release busy with queue full while presenting res_valid -> 4 consecutive wb_enable pulses in order 0x2000,0x2002,0x2004,0x2006; res_ready returns to 1 after the first dequeue.
REQ-031 Hold res_valid with the queue full for 300 cycles -> drop_count saturates at 255.
REQ-032 With BTB_UPDATE_COALESCE_EN defined and busy, enqueue pc=0x3000 tgt=0x3010, then pc=0x3000 tgt=0x3020 -> count=1; after busy drops, one write with tgt=0x3020.
REQ-033 Assert rst_n=0 for one cycle with 3 pending entries -> no further wb_enable, count=0, drop_count=0.
